serial_instr_receiver: RTL and testbench
========================================

Name: serial_instr_receiver

Overview:
- Receives one 10-bit servo instruction from the MBED over a bit-serial, four-phase ready/ack handshake.
- Presents the instruction to the servo-control state machine as a held word plus a one-cycle valid pulse.
- Sits directly upstream of the control FSM, which decodes bits [9:8] as opcode and [7:0] as position.
- Adds input synchronisation, glitch filtering on data_ready and a partial-frame timeout to eliminate wiped or shifted instructions.

Parameters:
- FRAME_BITS, 10, bits per instruction frame.
- STABLE_CYCLES, 4, consecutive synchronised samples needed to accept a data_ready level change.
- TIMEOUT_CYCLES, 2500000, cycles (50 ms at 50 MHz) allowed between handshake events inside a frame before it is discarded.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high; clears all state.
- data_ready  in  1  from MBED, asynchronous; high = data_bit valid.
- data_bit  in  1  from MBED, asynchronous serial data.
- data_ack  out  1  to MBED; high = current bit captured.
- servo_instr  out  FRAME_BITS  last complete instruction, held until the next frame completes.
- instr_valid  out  1  one-cycle pulse when servo_instr updates.
- frame_error  out  1  one-cycle pulse when a partial frame is discarded on timeout.
- state_dbg  out  2  current FSM state, for LEDs.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-high. While reset is high: data_ack=0, servo_instr=0, instr_valid=0, frame_error=0, state_dbg=0, bit_count=0, shift register=0, all counters=0.
  - Reset mid-frame discards the partial frame; no valid or error pulse is generated.
- Input conditioning:
  - data_ready and data_bit each pass through a 2-flop synchroniser.
  - ready_f is the filtered data_ready. It changes level only after STABLE_CYCLES consecutive synchronised samples at the new level. Any shorter excursion resets the filter count and is ignored.
- Bit order and storage:
  - Bits arrive MSB first. Bit 9 is the first bit of the frame.
  - Shift rule: shreg <= {shreg[FRAME_BITS-2:0], data_bit_sync}.
  - bit_count is 4 bits and counts from 0 to FRAME_BITS.
- FSM states (state_dbg encoding):
  - WAIT (0): data_ack=0. When ready_f rises, capture data_bit_sync into shreg and go to ACK. data_ack is registered high on that same edge.
  - ACK (2): data_ack=1. When ready_f falls, drop data_ack and increment bit_count.
    - If the new bit_count = FRAME_BITS, go to COMPLETE.
    - Otherwise go to WAIT.
  - COMPLETE (3): lasts one cycle.
    - servo_instr <= shreg and instr_valid=1.
    - bit_count <= 0, then return to WAIT.
  - Encoding 1 is reserved. If state ever equals 1, the FSM returns to WAIT and clears bit_count.
- Latency:
  - data_ack rises exactly 2+STABLE_CYCLES clock edges after the first edge that samples data_ready high, provided data_ready is held.
  - data_ack falls after the same delay measured from data_ready falling.
  - instr_valid pulses 1 cycle after data_ack falls for the last bit.
- Timeout:
  - The timeout counter runs in ACK, and in WAIT when bit_count>0.
  - It clears on every state transition.
  - When it reaches TIMEOUT_CYCLES-1:
    - Pulse frame_error.
    - Force data_ack=0, bit_count=0, shreg=0, state=WAIT.
    - Leave servo_instr unchanged.
  - After a timeout in ACK, ready_f must be seen low before a new bit is accepted, so a stuck-high line cannot be re-captured.
- Boundary rules:
  - If timeout terminal count and a qualifying ready_f edge occur in the same cycle, the edge wins and the counter clears.
  - No timeout in WAIT with bit_count=0; idle time is unlimited.
  - A new frame may start the cycle after COMPLETE. servo_instr holds its old value until that new frame completes.
  - instr_valid and frame_error never assert in the same cycle.

Decomposition:
- Shared package servo_pkg holds:
  - State encodings S_WAIT=0, S_ACK=2, S_COMPLETE=3.
  - FRAME_BITS.
  - Opcode field positions OPC_MSB=9, OPC_LSB=8, POS_MSB=7, and the opcode constants 01 turntable, 10 extend, 11 retract.
- One sub-module: level_sync_filter. It contains the 2-flop synchroniser plus the STABLE_CYCLES filter, with parameter STABLE_CYCLES.
  - Instantiated on data_ready.
  - data_bit uses the plain 2-flop stage only.

Test Plan (bench parameters: STABLE_CYCLES=4, TIMEOUT_CYCLES=200):
1. Clean frame 10'h271, with data_ready held 20 cycles high and 20 low per bit -> exactly 10 data_ack pulses; one instr_valid pulse; servo_instr=10'h271; frame_error never asserts.
2. Before bit 0, data_ready pulses high for 2 cycles then low -> no data_ack and no bit captured; a following frame 10'h155 yields servo_instr=10'h155.
3. Send 4 bits then go idle for 250 cycles -> frame_error pulses once, 200 cycles after the 4th data_ack falls; servo_instr keeps its prior value; next frame 10'h3FF yields 10'h3FF, unshifted.
4. Assert reset asynchronously while data_ack is high during bit 5 -> data_ack, servo_instr and state_dbg are 0 before the next clk edge; a subsequent frame 10'h2AA is received correctly.
5. After bit 2, data_ready is held high permanently -> timeout in ACK: frame_error pulses, data_ack drops, no re-capture until data_ready goes low.
6. Latency check: data_ack rises on the 6th edge after data_ready is sampled high; instr_valid pulses on the edge after the final data_ack falls.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared definitions for the serial servo instruction path: frame geometry,
// FSM state encodings and opcode field layout used by the control FSM.
package servo_pkg;

    localparam int FRAME_BITS = 10;
    localparam int BIT_CNT_W  = 4;

    // Instruction field positions: [9:8] opcode, [7:0] position
    localparam int OPC_MSB = 9;
    localparam int OPC_LSB = 8;
    localparam int POS_MSB = 7;
    localparam int POS_LSB = 0;

    localparam logic [1:0] OPC_TURNTABLE = 2'b01;
    localparam logic [1:0] OPC_EXTEND    = 2'b10;
    localparam logic [1:0] OPC_RETRACT   = 2'b11;

    // Encoding 2'd1 is reserved and never entered deliberately
    typedef enum logic [1:0] {
        S_WAIT     = 2'd0,
        S_ACK      = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    function automatic logic [1:0] instr_opcode(input logic [FRAME_BITS-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/serial_instr_if.sv
// MBED-side handshake plus instruction output bundle of the receiver.
interface serial_instr_if;
    import servo_pkg::*;

    logic                  data_ready;
    logic                  data_bit;
    logic                  data_ack;
    logic [FRAME_BITS-1:0] servo_instr;
    logic                  instr_valid;
    logic                  frame_error;
    logic [1:0]            state_dbg;

    modport master (
        output data_ready, data_bit,
        input  data_ack, servo_instr, instr_valid, frame_error, state_dbg
    );

    modport slave (
        input  data_ready, data_bit,
        output data_ack, servo_instr, instr_valid, frame_error, state_dbg
    );

endinterface

// File: rtl/level_sync_filter.sv
// Two-flop synchroniser followed by a level filter: the filtered level only
// changes after STABLE_CYCLES consecutive synchronised samples at the new
// level. Registered rise/fall pulses accompany each accepted level change.
module level_sync_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    logic             meta_r;
    logic             sync_r;
    logic             level_r;
    logic [CNT_W-1:0] cnt_r;
    logic             rise_r;
    logic             fall_r;

    // Bring the asynchronous input into the clock domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
        end
    end

    // Accept a new level only after an unbroken run of matching samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_r <= 1'b0;
            cnt_r   <= '0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else if (sync_r != level_r) begin
            if (cnt_r == CNT_W'(STABLE_CYCLES - 1)) begin
                level_r <= sync_r;
                cnt_r   <= '0;
                rise_r  <= sync_r;
                fall_r  <= ~sync_r;
            end else begin
                cnt_r  <= cnt_r + CNT_W'(1);
                rise_r <= 1'b0;
                fall_r <= 1'b0;
            end
        end else begin
            cnt_r  <= '0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/serial_instr_receiver.sv
// Bit-serial four-phase receiver for 10-bit servo instructions from the MBED.
// Captures MSB first, acknowledges each bit, publishes a held word with a
// one-cycle valid pulse and drops stalled partial frames on timeout.
module serial_instr_receiver
    import servo_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic           clk,
    input  logic           reset,
    serial_instr_if.slave  bus
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    logic                  ready_rise;
    logic                  ready_fall;
    logic                  bit_meta_r;
    logic                  bit_sync_r;

    state_t                state_r,  state_n;
    logic [BIT_CNT_W-1:0]  bit_cnt_r, bit_cnt_n;
    logic [FRAME_BITS-1:0] shreg_r,  shreg_n;
    logic [FRAME_BITS-1:0] instr_r,  instr_n;
    logic                  ack_r,    ack_n;
    logic                  valid_r,  valid_n;
    logic                  err_r,    err_n;
    logic [TMO_W-1:0]      tmo_r,    tmo_n;
    logic                  tmo_run;

    level_sync_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_ready_filter (
        .clk   (clk),
        .reset (reset),
        .din   (bus.data_ready),
        .rise  (ready_rise),
        .fall  (ready_fall)
    );

    // Plain two-flop synchroniser for the serial data line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_meta_r <= 1'b0;
            bit_sync_r <= 1'b0;
        end else begin
            bit_meta_r <= bus.data_bit;
            bit_sync_r <= bit_meta_r;
        end
    end

    // Next-state, datapath and output decode; a ready edge beats the timeout
    always_comb begin
        state_n   = state_r;
        bit_cnt_n = bit_cnt_r;
        shreg_n   = shreg_r;
        instr_n   = instr_r;
        ack_n     = ack_r;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        tmo_n     = '0;
        tmo_run   = 1'b0;
        case (state_r)
            S_WAIT: begin
                ack_n = 1'b0;
                if (ready_rise) begin
                    shreg_n = {shreg_r[FRAME_BITS-2:0], bit_sync_r};
                    ack_n   = 1'b1;
                    state_n = S_ACK;
                end else begin
                    tmo_run = (bit_cnt_r != BIT_CNT_W'(0));
                end
            end
            S_ACK: begin
                if (ready_fall) begin
                    ack_n     = 1'b0;
                    bit_cnt_n = bit_cnt_r + BIT_CNT_W'(1);
                    if (bit_cnt_n == BIT_CNT_W'(FRAME_BITS)) begin
                        state_n = S_COMPLETE;
                    end else begin
                        state_n = S_WAIT;
                    end
                end else begin
                    tmo_run = 1'b1;
                end
            end
            S_COMPLETE: begin
                instr_n   = shreg_r;
                valid_n   = 1'b1;
                bit_cnt_n = '0;
                state_n   = S_WAIT;
            end
            default: begin
                ack_n     = 1'b0;
                bit_cnt_n = '0;
                state_n   = S_WAIT;
            end
        endcase

        if (tmo_run) begin
            if (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                err_n     = 1'b1;
                ack_n     = 1'b0;
                bit_cnt_n = '0;
                shreg_n   = '0;
                state_n   = S_WAIT;
                tmo_n     = '0;
            end else begin
                tmo_n = tmo_r + TMO_W'(1);
            end
        end else begin
            tmo_n = '0;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_WAIT;
            bit_cnt_r <= '0;
            shreg_r   <= '0;
            instr_r   <= '0;
            ack_r     <= 1'b0;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
            tmo_r     <= '0;
        end else begin
            state_r   <= state_n;
            bit_cnt_r <= bit_cnt_n;
            shreg_r   <= shreg_n;
            instr_r   <= instr_n;
            ack_r     <= ack_n;
            valid_r   <= valid_n;
            err_r     <= err_n;
            tmo_r     <= tmo_n;
        end
    end

    assign bus.data_ack    = ack_r;
    assign bus.servo_instr = instr_r;
    assign bus.instr_valid = valid_r;
    assign bus.frame_error = err_r;
    assign bus.state_dbg   = state_r;

endmodule

// File: tb/tb_serial_instr_receiver.sv
// Directed bench for serial_instr_receiver with STABLE_CYCLES=4 and
// TIMEOUT_CYCLES=200. Expected values are hand-computed constants.
module tb_serial_instr_receiver;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int   cyc = 0;
    int   ack_total = 0;
    int   valid_total = 0;
    int   err_total = 0;
    int   both_total = 0;
    int   last_fall_cyc = 0;
    int   last_err_cyc = 0;
    logic ack_prev = 1'b0;

    serial_instr_if bus ();

    serial_instr_receiver #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Event monitor: counts ack pulses, valid/error pulses and their timing
    always @(negedge clk) begin
        if (bus.data_ack === 1'b1 && ack_prev === 1'b0) ack_total++;
        if (bus.data_ack === 1'b0 && ack_prev === 1'b1) last_fall_cyc = cyc;
        ack_prev = bus.data_ack;
        if (bus.instr_valid === 1'b1) valid_total++;
        if (bus.frame_error === 1'b1) begin
            err_total++;
            last_err_cyc = cyc;
        end
        if (bus.instr_valid === 1'b1 && bus.frame_error === 1'b1) both_total++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.data_bit   = b;
        bus.data_ready = 1'b1;
        repeat (20) @(negedge clk);
        bus.data_ready = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_frame(input logic [9:0] v);
        for (int i = 9; i >= 0; i--) send_bit(v[i]);
        repeat (5) @(negedge clk);
    endtask

    // One handshake bit, measuring edges from driving ready to each ack change
    task automatic timed_bit(input logic b, output int rise_k, output int fall_k);
        @(negedge clk);
        bus.data_bit   = b;
        bus.data_ready = 1'b1;
        rise_k = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (bus.data_ack === 1'b1) begin rise_k = k; break; end
        end
        repeat (10) @(negedge clk);
        bus.data_ready = 1'b0;
        fall_k = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (bus.data_ack === 1'b0) begin fall_k = k; break; end
        end
    endtask

    initial begin
        int a0, v0, e0, rk, fk, found;
        logic [9:0] fr;
        bus.data_ready = 1'b0;
        bus.data_bit   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack",   bus.data_ack,    32'd0);
        chk("rst_instr", bus.servo_instr, 32'd0);
        chk("rst_valid", bus.instr_valid, 32'd0);
        chk("rst_err",   bus.frame_error, 32'd0);
        chk("rst_state", bus.state_dbg,   32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 1: clean frame
        a0 = ack_total; v0 = valid_total; e0 = err_total;
        send_frame(10'h271);
        chk("t1_acks",  ack_total - a0,   32'd10);
        chk("t1_valid", valid_total - v0, 32'd1);
        chk("t1_instr", bus.servo_instr,  32'h271);
        chk("t1_err",   err_total - e0,   32'd0);
        chk("t1_state", bus.state_dbg,    32'd0);

        // 2: short glitch on data_ready is ignored
        a0 = ack_total; v0 = valid_total;
        bus.data_bit = 1'b1;
        bus.data_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.data_ready = 1'b0;
        repeat (20) @(negedge clk);
        chk("t2_glitch_ack", ack_total - a0, 32'd0);
        send_frame(10'h155);
        chk("t2_instr", bus.servo_instr,  32'h155);
        chk("t2_acks",  ack_total - a0,   32'd10);
        chk("t2_valid", valid_total - v0, 32'd1);

        // 3: partial frame times out 200 cycles after last ack falls
        v0 = valid_total; e0 = err_total;
        fr = 10'h2D3;
        for (int i = 9; i >= 6; i--) send_bit(fr[i]);
        repeat (250) @(negedge clk);
        chk("t3_err_cnt",   err_total - e0,               32'd1);
        chk("t3_err_delay", last_err_cyc - last_fall_cyc, 32'd200);
        chk("t3_instr_hold", bus.servo_instr,             32'h155);
        chk("t3_no_valid",  valid_total - v0,             32'd0);
        send_frame(10'h3FF);
        chk("t3_instr_new", bus.servo_instr, 32'h3FF);
        chk("t3_valid",     valid_total - v0, 32'd1);

        // 4: asynchronous reset while bit 5 is acknowledged
        v0 = valid_total; e0 = err_total;
        fr = 10'h0F0;
        for (int i = 9; i >= 6; i--) send_bit(fr[i]);
        @(negedge clk);
        bus.data_bit = 1'b1;
        bus.data_ready = 1'b1;
        found = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.data_ack === 1'b1) begin found = 1; break; end
        end
        chk("t4_ack_seen", found, 32'd1);
        #2 reset = 1'b1;
        bus.data_ready = 1'b0;
        #1;
        chk("t4_ack",   bus.data_ack,    32'd0);
        chk("t4_instr", bus.servo_instr, 32'd0);
        chk("t4_state", bus.state_dbg,   32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_no_valid", valid_total - v0, 32'd0);
        chk("t4_no_err",   err_total - e0,   32'd0);
        send_frame(10'h2AA);
        chk("t4_instr_new", bus.servo_instr, 32'h2AA);

        // 5: data_ready stuck high after bit 2 times out in ACK
        a0 = ack_total; v0 = valid_total; e0 = err_total;
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        bus.data_bit = 1'b1;
        bus.data_ready = 1'b1;
        repeat (300) @(negedge clk);
        chk("t5_err",   err_total - e0, 32'd1);
        chk("t5_ack",   bus.data_ack,   32'd0);
        chk("t5_acks",  ack_total - a0, 32'd3);
        chk("t5_state", bus.state_dbg,  32'd0);
        bus.data_ready = 1'b0;
        repeat (30) @(negedge clk);
        chk("t5_no_recap", ack_total - a0,   32'd3);
        chk("t5_no_valid", valid_total - v0, 32'd0);
        chk("t5_instr",    bus.servo_instr,  32'h2AA);
        send_frame(10'h1C6);
        chk("t5_instr_new", bus.servo_instr, 32'h1C6);

        // 6: latency; ack changes on the 6th edge after the sampling edge,
        // i.e. the 7th edge after data_ready is driven
        fr = 10'h2C5;
        timed_bit(fr[9], rk, fk);
        chk("t6_rise_lat", rk, 32'd7);
        chk("t6_fall_lat", fk, 32'd7);
        for (int i = 8; i >= 1; i--) send_bit(fr[i]);
        timed_bit(fr[0], rk, fk);
        chk("t6_last_fall", fk, 32'd7);
        chk("t6_valid_pre", bus.instr_valid, 32'd0);
        @(posedge clk); #1;
        chk("t6_valid",     bus.instr_valid, 32'd1);
        chk("t6_instr",     bus.servo_instr, 32'h2C5);
        @(posedge clk); #1;
        chk("t6_valid_end", bus.instr_valid, 32'd0);
        repeat (10) @(negedge clk);

        chk("no_valid_err_overlap", both_total, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
